// File: rtl/parity_transmitter_if.sv
// Request/data/pulse bundle for parity_transmitter.
// The master drives start/data; the slave (transmitter) drives the pulse and status outputs.
interface parity_transmitter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] data;
   logic             bit_zero;
   logic             bit_one;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output data,
      input  bit_zero,
      input  bit_one,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data,
      output bit_zero,
      output bit_one,
      output busy,
      output done
   );
endinterface

// File: rtl/parity_transmitter.sv
// Serialises a captured word MSB first as bit_zero/bit_one pulses, followed by a parity pulse.
// Define PARITY_TX_ODD_EN to select odd parity; even parity is used otherwise.
module parity_transmitter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned BIT_PERIOD = 100000000
) (
   input  logic                  clk_100Mhz,
   input  logic                  reset_n,
   parity_transmitter_if.slave   bus
);

   typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;

   localparam logic [31:0] PeriodLast = 32'(BIT_PERIOD - 1);
   localparam logic [31:0] PeriodFull = 32'(BIT_PERIOD);
   localparam logic [5:0]  BitLast    = 6'(WIDTH - 1);

   state_e           state;
   logic             start_meta;
   logic             start_sync;
   logic             start_prev;
   logic             sync_filled;
   logic             armed;
   logic             req;
   logic             data_parity;
   logic [WIDTH-1:0] shift_reg;
   logic             parity_bit;
   logic [5:0]       bit_cnt;
   logic [31:0]      period_cnt;
   logic             bit_zero_q;
   logic             bit_one_q;
   logic             busy_q;
   logic             done_q;

`ifdef PARITY_TX_ODD_EN
   assign data_parity = ~(^bus.data);
`else
   assign data_parity = ^bus.data;
`endif

   // Only arm once the input has been seen low after reset, so a button held
   // through reset release cannot fake a press.
   always_ff @(posedge clk_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         start_meta  <= 1'b0;
         start_sync  <= 1'b0;
         start_prev  <= 1'b0;
         sync_filled <= 1'b0;
         armed       <= 1'b0;
      end else begin
         start_meta  <= bus.start;
         start_sync  <= start_meta;
         start_prev  <= start_sync;
         sync_filled <= 1'b1;
         if (sync_filled && !start_meta) begin
            armed <= 1'b1;
         end
      end
   end

   assign req = start_sync & ~start_prev & armed;

   always_ff @(posedge clk_100Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= StIdle;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         bit_cnt    <= '0;
         period_cnt <= '0;
         bit_zero_q <= 1'b0;
         bit_one_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         bit_zero_q <= 1'b0;
         bit_one_q  <= 1'b0;
         done_q     <= 1'b0;
         case (state)
            StIdle: begin
               if (req) begin
                  shift_reg  <= bus.data;
                  parity_bit <= data_parity;
                  bit_cnt    <= '0;
                  period_cnt <= '0;
                  busy_q     <= 1'b1;
                  state      <= StShift;
               end
            end
            StShift: begin
               if (period_cnt == PeriodLast) begin
                  period_cnt <= '0;
                  bit_one_q  <= shift_reg[WIDTH-1];
                  bit_zero_q <= ~shift_reg[WIDTH-1];
                  shift_reg  <= shift_reg << 1;
                  bit_cnt    <= bit_cnt + 6'd1;
                  if (bit_cnt == BitLast) begin
                     state <= StParity;
                  end
               end else begin
                  period_cnt <= period_cnt + 32'd1;
               end
            end
            StParity: begin
               // Runs one cycle past the parity pulse so done lands a cycle later.
               if (period_cnt == PeriodFull) begin
                  period_cnt <= '0;
                  done_q     <= 1'b1;
                  state      <= StDone;
               end else begin
                  period_cnt <= period_cnt + 32'd1;
                  if (period_cnt == PeriodLast) begin
                     bit_one_q  <= parity_bit;
                     bit_zero_q <= ~parity_bit;
                  end
               end
            end
            StDone: begin
               busy_q <= 1'b0;
               state  <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign bus.bit_zero = bit_zero_q;
   assign bus.bit_one  = bit_one_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_parity_transmitter.sv
// Directed table-driven bench for parity_transmitter with WIDTH=8, BIT_PERIOD=4.
module tb_parity_transmitter;

   typedef struct {
      logic [7:0] data;
      int         hold;
      bit         repress;
      logic [8:0] bits;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[7];

   parity_transmitter_if #(.WIDTH(8)) bus_if ();

   parity_transmitter #(
      .WIDTH      (8),
      .BIT_PERIOD (4)
   ) dut (
      .clk_100Mhz (clk),
      .reset_n    (reset_n),
      .bus        (bus_if.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] outs();
      return {bus_if.busy, bus_if.done, bus_if.bit_one, bus_if.bit_zero};
   endfunction

   task automatic check(input string nm, input int id, input int k, input logic [3:0] act,
                        input logic [3:0] exp_o);
      checks++;
      if (act !== exp_o) begin
         errors++;
         $display("FAIL %s vec %0d cyc %0d: {busy,done,one,zero} got %b want %b",
                  nm, id, k, act, exp_o);
      end
   endtask

   // Cycle k is counted in negedge samples from the capture edge (k=0 first busy sample).
   task automatic run_frame(input vec_t v, input int id);
      logic [8:0] bits;
      logic [3:0] exp_o;
      int         k;
      int         last;
      bits = v.bits;
`ifdef PARITY_TX_ODD_EN
      bits[0] = ~bits[0];
`endif
      last = (v.hold > 41) ? v.hold + 8 : 48;
      bus_if.data = v.data;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         k = c - 3;
         exp_o = 4'b0000;
         if (k >= 0 && k <= 37) exp_o[3] = 1'b1;
         if (k == 37) exp_o[2] = 1'b1;
         if (k > 0 && k <= 36 && (k % 4) == 0) begin
            exp_o[1] = bits[8 - (k / 4 - 1)];
            exp_o[0] = ~bits[8 - (k / 4 - 1)];
         end
         check("frame", id, k, outs(), exp_o);
         bus_if.start = (c < v.hold) || (v.repress && c >= 13 && c < 19);
         if (v.repress && c == 13) bus_if.data = 8'hFF;
      end
      bus_if.start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, hold: 3,   repress: 1'b0, bits: 9'b101001010};
      vecs[1] = '{data: 8'h07, hold: 5,   repress: 1'b0, bits: 9'b000001111};
      vecs[2] = '{data: 8'h00, hold: 3,   repress: 1'b0, bits: 9'b000000000};
      vecs[3] = '{data: 8'hA5, hold: 4,   repress: 1'b1, bits: 9'b101001010};
      vecs[4] = '{data: 8'hA5, hold: 200, repress: 1'b0, bits: 9'b101001010};
      vecs[5] = '{data: 8'h80, hold: 3,   repress: 1'b0, bits: 9'b100000001};
      vecs[6] = '{data: 8'h3C, hold: 10,  repress: 1'b0, bits: 9'b001111000};

      bus_if.start = 1'b0;
      bus_if.data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_state", 0, 0, outs(), 4'b0000);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i], i);
      end

      // Abort mid-frame with reset, then a fresh press must produce a full frame.
      bus_if.data  = 8'hA5;
      bus_if.start = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_capture", 10, 0, outs(), 4'b1000);
      bus_if.start = 1'b0;
      repeat (14) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_reset", 10, 14, outs(), 4'b0000);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         check("abort_quiet", 10, c, outs(), 4'b0000);
      end
      run_frame(vecs[0], 11);

      // Start held through reset release must not trigger until pressed again.
      @(negedge clk);
      reset_n = 1'b0;
      bus_if.start = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("held_reset", 12, c, outs(), 4'b0000);
      end
      bus_if.start = 1'b0;
      repeat (5) @(negedge clk);
      check("held_release", 12, 0, outs(), 4'b0000);
      run_frame(vecs[1], 13);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_transmitter.md
PARITY_TRANSMITTER -- requirements
Module: parity_transmitter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the number of data bits per frame (legal range 1 to 32).
REQ-002 The module SHALL have parameter BIT_PERIOD, default 100000000, the number of clk_100Mhz cycles per transmitted bit (legal range 2 to 2^32-1).
REQ-003 The module SHALL have port clk_100Mhz  input  1  single system clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1  raw push-button request, asynchronous to clk_100Mhz.
REQ-006 The module SHALL have port data  input  WIDTH  word to transmit, sampled only at frame capture.
REQ-007 The module SHALL have port bit_zero  output  1  one-cycle pulse marking a transmitted 0.
REQ-008 The module SHALL have port bit_one  output  1  one-cycle pulse marking a transmitted 1.
REQ-009 The module SHALL have port busy  output  1  high from frame capture until the done pulse, inclusive.
REQ-010 The module SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-011 start SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, so that one press yields exactly one request regardless of hold time.
REQ-012 A start rising edge that is stable for at least 3 cycles SHALL cause frame capture on the third rising clock edge after it, with busy=1 from that edge onward.
REQ-013 The FSM SHALL have exactly four states: IDLE, SHIFT, PARITY, DONE.
REQ-014 IDLE->SHIFT SHALL occur on the detected request edge, at which time data is captured into a shift register, the bit counter is cleared and the period counter is cleared.
REQ-015 In SHIFT, the period counter SHALL count 0..BIT_PERIOD-1; when it reaches BIT_PERIOD-1, the module SHALL emit the current bit (MSB first), shift, increment the bit counter and wrap the period counter to 0.
REQ-016 The first data-bit pulse SHALL occur exactly BIT_PERIOD cycles after capture, with subsequent pulses every BIT_PERIOD cycles.
REQ-017 The emission of bit WIDTH-1 (the LSB) SHALL cause SHIFT->PARITY.
REQ-018 In PARITY, the module SHALL emit the parity bit BIT_PERIOD cycles after the LSB pulse, then move to DONE.
REQ-019 In DONE, done=1 and busy=1 SHALL hold for exactly one cycle, followed by an unconditional return to IDLE with busy=0.
REQ-020 Per emitted bit, exactly one of bit_zero or bit_one SHALL be high, for one cycle only; both SHALL be 0 at all other times.
REQ-021 Parity SHALL be computed from the captured word only; later changes on data SHALL have no effect on the frame.
REQ-022 Request edges detected while busy=1 SHALL be discarded and SHALL NOT be queued.
REQ-023 A request edge coinciding with the DONE cycle SHALL be discarded.
REQ-024 A frame SHALL total WIDTH+1 pulses; the done pulse SHALL occur (WIDTH+1)*BIT_PERIOD+1 cycles after capture.

Reset
REQ-025 reset_n=0 SHALL immediately force bit_zero=0, bit_one=0, busy=0, done=0, FSM to IDLE, and clear all counters, the shift register and the synchronizer flops.
REQ-026 Assertion of reset_n mid-frame SHALL abort the frame with no further pulses.
REQ-027 A start held high through reset deassertion SHALL NOT generate a request until it is released and pressed again.

Configuration
REQ-028 With macro PARITY_TX_ODD_EN defined, the parity bit SHALL equal the inverted XOR of the captured word, so the total ones per frame is odd.
REQ-029 Without PARITY_TX_ODD_EN, the parity bit SHALL equal the XOR of the captured word, so the total ones per frame is even.

Verification (WIDTH=8, BIT_PERIOD=4)
REQ-030 Even mode, data=8'hA5, one press -> pulses one,zero,one,zero,zero,one,zero,one, then parity zero at capture+36 cycles; done at capture+37.
REQ-031 data=8'h07 -> parity pulse is bit_one without the macro and bit_zero with PARITY_TX_ODD_EN defined.
REQ-032 Second press at capture+10 with data changed to 8'hFF -> ignored; the frame still transmits 8'hA5 and exactly 9 pulses occur.
REQ-033 start held high for 200 cycles -> exactly one frame and one done pulse.
REQ-034 reset_n low at capture+14 -> all outputs 0 in the same cycle, no further pulses; a new press after release yields a full correct frame.
REQ-035 data=8'h00, even mode -> nine bit_zero pulses spaced 4 cycles apart, and no bit_one pulses.
